// File: rtl/gen_fifo_defines_pkg.sv
// Purpose : shared constants and types for the generator FIFO path and its N-channel output mux.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package gen_fifo_defines_pkg;

    // Sample width used throughout the generator datapath.
    localparam int GEN_DATA_WIDTH       = 16;

    // Defaults for the N-channel generator output mux.
    localparam int GEN_MUX_NUM_CH       = 8;
    localparam int GEN_MUX_BLANK_CYCLES = 2;
    localparam int GEN_MUX_DROP_CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        BLANK
    } mux_state_e;

    // The blank counter is loaded with cycles-1, so it needs clog2(cycles) bits;
    // keep at least one bit so the register exists for 0/1/2-cycle configurations.
    function automatic int blank_cnt_width(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/funct_generator_out_reg.sv
// Purpose : single valid/ready output register feeding the generator FIFO, plus saturating drop counter.
// Latency : 1 cycle from sample/produce to data_o/valid_o.
// Backpressure: while valid_o && !ready_i the register holds; each sample produced then is dropped and counted.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   flush            clear the register (mux disabled); not counted as a drop
//   produce, sample  a new sample is offered this cycle
//   ready_i          downstream ready
//   data_o, valid_o  registered sample and its valid
//   drop_cnt_o       saturating count of dropped samples
// Build option: GEN_MUX_DROP_CNT_EN enables the drop counter; otherwise drop_cnt_o is tied to 0.
module funct_generator_out_reg
    import gen_fifo_defines_pkg::*;
#(
    parameter int DATA_WIDTH = GEN_DATA_WIDTH,
    parameter int DROP_CNT_W = GEN_MUX_DROP_CNT_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         produce,
    input  logic signed [DATA_WIDTH-1:0] sample,
    input  logic                         ready_i,
    output logic signed [DATA_WIDTH-1:0] data_o,
    output logic                         valid_o,
    output logic        [DROP_CNT_W-1:0] drop_cnt_o
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_o  <= '0;
            valid_o <= 1'b0;
        end else if (flush) begin
            data_o  <= '0;
            valid_o <= 1'b0;
        end else if (produce && (!valid_o || ready_i)) begin
            data_o  <= sample;
            valid_o <= 1'b1;
        end else if (ready_i) begin
            // Accepted with nothing new to load.
            valid_o <= 1'b0;
        end
    end

`ifdef GEN_MUX_DROP_CNT_EN
    // A produced sample is lost exactly when the register is full and not being drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_o <= '0;
        end else if (produce && !flush && valid_o && !ready_i && (drop_cnt_o != '1)) begin
            drop_cnt_o <= drop_cnt_o + 1'b1;
        end
    end
`else
    assign drop_cnt_o = '0;
`endif

endmodule

// File: rtl/funct_generator_mux_n.sv
// Purpose : N-channel signed generator output mux with zero-valued blanking gap on channel switch.
// Latency : 1 cycle from data_i/sel_i to data_o (first sample one cycle after enable is latched).
// Backpressure: valid/ready output register; held while !ready_i, samples produced meanwhile are dropped and counted.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   enh            mux enable; low flushes the output and returns to IDLE
//   sel_i          requested channel
//   data_i         packed channels, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   ready_i        downstream (FIFO) ready
//   data_o/valid_o registered sample and valid
//   active_sel_o   currently latched channel
//   blanking_o     high while in BLANK
//   drop_cnt_o     saturating dropped-sample count (only with GEN_MUX_DROP_CNT_EN defined)
module funct_generator_mux_n
    import gen_fifo_defines_pkg::*;
#(
    parameter int DATA_WIDTH   = GEN_DATA_WIDTH,
    parameter int NUM_CH       = GEN_MUX_NUM_CH,
    parameter int BLANK_CYCLES = GEN_MUX_BLANK_CYCLES,
    parameter int DROP_CNT_W   = GEN_MUX_DROP_CNT_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enh,
    input  logic [$clog2(NUM_CH)-1:0]        sel_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0]     data_i,
    input  logic                             ready_i,
    output logic signed [DATA_WIDTH-1:0]     data_o,
    output logic                             valid_o,
    output logic [$clog2(NUM_CH)-1:0]        active_sel_o,
    output logic                             blanking_o,
    output logic [DROP_CNT_W-1:0]            drop_cnt_o
);

    localparam int SEL_W  = $clog2(NUM_CH);
    localparam int BCNT_W = blank_cnt_width(BLANK_CYCLES);

    mux_state_e                   state;
    logic [BCNT_W-1:0]            blank_cnt;
    logic signed [DATA_WIDTH-1:0] sample;
    logic                         produce;
    logic                         flush;

    // Explicit compare per channel so an out-of-range latched select yields 0, never X.
    // BLANK leaves the default zero in place.
    always_comb begin
        sample = '0;
        if (state == RUN) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (active_sel_o == SEL_W'(k)) begin
                    sample = data_i[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign produce = enh && (state != IDLE);
    assign flush   = !enh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            active_sel_o <= '0;
            blanking_o   <= 1'b0;
            blank_cnt    <= '0;
        end else if (!enh) begin
            state      <= IDLE;
            blanking_o <= 1'b0;
            blank_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // First enable: no gap, the requested channel is taken directly.
                    state        <= RUN;
                    active_sel_o <= sel_i;
                end
                RUN: begin
                    if (sel_i != active_sel_o) begin
                        if (BLANK_CYCLES == 0) begin
                            active_sel_o <= sel_i;
                        end else begin
                            state      <= BLANK;
                            blank_cnt  <= BCNT_W'(BLANK_CYCLES - 1);
                            blanking_o <= 1'b1;
                        end
                    end
                end
                BLANK: begin
                    // sel_i is only sampled on exit, so toggling it here never restarts the gap.
                    if (blank_cnt == '0) begin
                        state        <= RUN;
                        active_sel_o <= sel_i;
                        blanking_o   <= 1'b0;
                    end else begin
                        blank_cnt <= blank_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    funct_generator_out_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .DROP_CNT_W (DROP_CNT_W)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .produce    (produce),
        .sample     (sample),
        .ready_i    (ready_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .drop_cnt_o (drop_cnt_o)
    );

endmodule

// File: tb/tb_funct_generator_mux_n.sv
// Purpose : self-checking bench for funct_generator_mux_n (8ch/2-blank/8-bit count and 6ch/0-blank/2-bit count).
// Latency : expectations are queued as stimulus is applied and popped one cycle later.
// Backpressure: exercised with ready_i held low in RUN on both instances.
module tb_funct_generator_mux_n;

    localparam int DW = 16;
`ifdef GEN_MUX_DROP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk;
    logic rst;

    // Instance A: 8 channels, 2 blank cycles, 8-bit drop counter.
    logic              enh_a, rdy_a;
    logic [2:0]        sel_a;
    logic [8*DW-1:0]   data_a;
    logic [DW-1:0]     dout_a;
    logic              vld_a, blank_a;
    logic [2:0]        asel_a;
    logic [7:0]        drop_a;

    // Instance B: 6 channels, no blanking, 2-bit drop counter.
    logic              enh_b, rdy_b;
    logic [2:0]        sel_b;
    logic [6*DW-1:0]   data_b;
    logic [DW-1:0]     dout_b;
    logic              vld_b, blank_b;
    logic [2:0]        asel_b;
    logic [1:0]        drop_b;

    typedef struct {
        logic [15:0] d;
        logic        v;
        logic        b;
        logic [2:0]  s;
        logic [7:0]  c;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    funct_generator_mux_n #(
        .DATA_WIDTH(DW), .NUM_CH(8), .BLANK_CYCLES(2), .DROP_CNT_W(8)
    ) dut_a (
        .clk(clk), .rst(rst), .enh(enh_a), .sel_i(sel_a), .data_i(data_a), .ready_i(rdy_a),
        .data_o(dout_a), .valid_o(vld_a), .active_sel_o(asel_a), .blanking_o(blank_a),
        .drop_cnt_o(drop_a)
    );

    funct_generator_mux_n #(
        .DATA_WIDTH(DW), .NUM_CH(6), .BLANK_CYCLES(0), .DROP_CNT_W(2)
    ) dut_b (
        .clk(clk), .rst(rst), .enh(enh_b), .sel_i(sel_b), .data_i(data_b), .ready_i(rdy_b),
        .data_o(dout_b), .valid_o(vld_b), .active_sel_o(asel_b), .blanking_o(blank_b),
        .drop_cnt_o(drop_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void push_exp(input logic [15:0] d, input logic v, input logic b,
                                     input logic [2:0] s, input logic [7:0] c);
        exp_t e;
        e.d = d; e.v = v; e.b = b; e.s = s; e.c = c;
        sbq.push_back(e);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        enh_a = 1'b0; rdy_a = 1'b1; sel_a = 3'd0; data_a = '0;
        enh_b = 1'b0; rdy_b = 1'b1; sel_b = 3'd0; data_b = '0;
        tick();
        tick();
        checks++;
        if ({dout_a, vld_a, blank_a, asel_a, drop_a} !== 29'd0) begin
            errors++;
            $display("FAIL reset_a: got d=%h v=%b b=%b s=%0d c=%0d, want all 0", dout_a, vld_a, blank_a, asel_a, drop_a);
        end
        checks++;
        if ({dout_b, vld_b, blank_b, asel_b, drop_b} !== 23'd0) begin
            errors++;
            $display("FAIL reset_b: got d=%h v=%b b=%b s=%0d c=%0d, want all 0", dout_b, vld_b, blank_b, asel_b, drop_b);
        end

        @(negedge clk);
        rst = 1'b0;
        data_a[1*DW +: DW] = 16'h1234;
        sel_a = 3'd1;
        enh_a = 1'b1;
        tick();
        checks++;
        if (vld_a !== 1'b0 || asel_a !== 3'd1) begin
            errors++;
            $display("FAIL first_enable: got v=%b s=%0d, want v=0 s=1", vld_a, asel_a);
        end
        tick();
        checks++;
        if (dout_a !== 16'h1234 || vld_a !== 1'b1) begin
            errors++;
            $display("FAIL first_sample: got d=%h v=%b, want d=1234 v=1", dout_a, vld_a);
        end

        // Asynchronous reset in the middle of a cycle while a sample is valid.
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({dout_a, vld_a, blank_a, asel_a, drop_a} !== 29'd0) begin
            errors++;
            $display("FAIL async_reset: got d=%h v=%b b=%b s=%0d c=%0d, want all 0", dout_a, vld_a, blank_a, asel_a, drop_a);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++;
        if (vld_a !== 1'b0) begin
            errors++;
            $display("FAIL release_first_clk: got v=%b, want 0", vld_a);
        end
        tick();
        checks++;
        if (dout_a !== 16'h1234 || vld_a !== 1'b1) begin
            errors++;
            $display("FAIL release_sample: got d=%h v=%b, want d=1234 v=1", dout_a, vld_a);
        end
    endtask

    logic [15:0] last5;

    task automatic test_select();
        exp_t e;
        logic [15:0] r;
        // Disable, then re-enable on channel 5.
        enh_a = 1'b0;
        push_exp(16'h0, 1'b0, 1'b0, 3'd1, 8'd0);
        tick();
        e = sbq.pop_front();
        checks++;
        if ({dout_a, vld_a, blank_a, asel_a, drop_a} !== {e.d, e.v, e.b, e.s, e.c}) begin
            errors++;
            $display("FAIL select_disable: got d=%h v=%b b=%b s=%0d c=%0d, want d=%h v=%b b=%b s=%0d c=%0d",
                     dout_a, vld_a, blank_a, asel_a, drop_a, e.d, e.v, e.b, e.s, e.c);
        end
        for (int k = 0; k < 8; k++) data_a[k*DW +: DW] = 16'(k * 16'h1111);
        data_a[5*DW +: DW] = 16'hFFFD;
        sel_a = 3'd5;
        enh_a = 1'b1;
        push_exp(16'h0, 1'b0, 1'b0, 3'd5, 8'd0);
        push_exp(16'hFFFD, 1'b1, 1'b0, 3'd5, 8'd0);
        for (int i = 0; i < 5; i++) begin
            if (i >= 2) begin
                r = 16'($urandom_range(1, 65535));
                data_a[5*DW +: DW] = r;
                data_a[4*DW +: DW] = 16'($urandom);
                data_a[6*DW +: DW] = 16'($urandom);
                push_exp(r, 1'b1, 1'b0, 3'd5, 8'd0);
                last5 = r;
            end
            tick();
            e = sbq.pop_front();
            checks++;
            if ({dout_a, vld_a, blank_a, asel_a, drop_a} !== {e.d, e.v, e.b, e.s, e.c}) begin
                errors++;
                $display("FAIL select_ch5[%0d]: got d=%h v=%b b=%b s=%0d c=%0d, want d=%h v=%b b=%b s=%0d c=%0d",
                         i, dout_a, vld_a, blank_a, asel_a, drop_a, e.d, e.v, e.b, e.s, e.c);
            end
        end
    endtask

    task automatic test_blank();
        exp_t e;
        logic [2:0]  sels  [6] = '{3'd2, 3'd3, 3'd2, 3'd2, 3'd2, 3'd2};
        int zeros = 0;
        // Switch 5 -> 2, with a 3/2 toggle inside the gap.
        push_exp(last5,    1'b1, 1'b1, 3'd5, 8'd0);
        push_exp(16'h0,    1'b1, 1'b1, 3'd5, 8'd0);
        push_exp(16'h0,    1'b1, 1'b0, 3'd2, 8'd0);
        push_exp(16'h2222, 1'b1, 1'b0, 3'd2, 8'd0);
        push_exp(16'h2222, 1'b1, 1'b0, 3'd2, 8'd0);
        push_exp(16'h2222, 1'b1, 1'b0, 3'd2, 8'd0);
        for (int i = 0; i < 6; i++) begin
            sel_a = sels[i];
            tick();
            if (vld_a === 1'b1 && dout_a === 16'h0) zeros++;
            e = sbq.pop_front();
            checks++;
            if ({dout_a, vld_a, blank_a, asel_a, drop_a} !== {e.d, e.v, e.b, e.s, e.c}) begin
                errors++;
                $display("FAIL blank_seq[%0d]: got d=%h v=%b b=%b s=%0d c=%0d, want d=%h v=%b b=%b s=%0d c=%0d",
                         i, dout_a, vld_a, blank_a, asel_a, drop_a, e.d, e.v, e.b, e.s, e.c);
            end
        end
        checks++;
        if (zeros != 2) begin
            errors++;
            $display("FAIL blank_zero_count: got %0d zero samples, want 2", zeros);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        data_a[2*DW +: DW] = 16'h0AAA;
        rdy_a = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            if (i == 6) begin
                rdy_a = 1'b1;
                push_exp(16'h0AAA, 1'b1, 1'b0, 3'd2, CNT_EN ? 8'd5 : 8'd0);
            end else begin
                push_exp(16'h2222, 1'b1, 1'b0, 3'd2, CNT_EN ? 8'(i) : 8'd0);
            end
            tick();
            e = sbq.pop_front();
            checks++;
            if ({dout_a, vld_a, blank_a, asel_a, drop_a} !== {e.d, e.v, e.b, e.s, e.c}) begin
                errors++;
                $display("FAIL backpressure[%0d]: got d=%h v=%b b=%b s=%0d c=%0d, want d=%h v=%b b=%b s=%0d c=%0d",
                         i, dout_a, vld_a, blank_a, asel_a, drop_a, e.d, e.v, e.b, e.s, e.c);
            end
        end
    endtask

    task automatic test_enh_drop();
        exp_t e;
        data_a[2*DW +: DW] = 16'h0BBB;
        rdy_a = 1'b0;
        enh_a = 1'b0;
        push_exp(16'h0, 1'b0, 1'b0, 3'd2, CNT_EN ? 8'd5 : 8'd0);
        push_exp(16'h0, 1'b0, 1'b0, 3'd2, CNT_EN ? 8'd5 : 8'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            e = sbq.pop_front();
            checks++;
            if ({dout_a, vld_a, blank_a, asel_a, drop_a} !== {e.d, e.v, e.b, e.s, e.c}) begin
                errors++;
                $display("FAIL enh_drop[%0d]: got d=%h v=%b b=%b s=%0d c=%0d, want d=%h v=%b b=%b s=%0d c=%0d",
                         i, dout_a, vld_a, blank_a, asel_a, drop_a, e.d, e.v, e.b, e.s, e.c);
            end
        end
    endtask

    task automatic test_oob_nogap();
        exp_t e;
        logic [2:0] sels [4] = '{3'd1, 3'd1, 3'd7, 3'd7};
        for (int k = 0; k < 6; k++) data_b[k*DW +: DW] = 16'((k + 1) * 16'h1111 - 16'h1111);
        data_b[1*DW +: DW] = 16'h1111;
        rdy_b = 1'b1;
        enh_b = 1'b1;
        push_exp(16'h0,    1'b0, 1'b0, 3'd1, 8'd0);
        push_exp(16'h1111, 1'b1, 1'b0, 3'd1, 8'd0);
        push_exp(16'h1111, 1'b1, 1'b0, 3'd7, 8'd0);
        push_exp(16'h0,    1'b1, 1'b0, 3'd7, 8'd0);
        for (int i = 0; i < 4; i++) begin
            sel_b = sels[i];
            tick();
            e = sbq.pop_front();
            checks++;
            if ({dout_b, vld_b, blank_b, asel_b, 6'd0, drop_b} !== {e.d, e.v, e.b, e.s, e.c}) begin
                errors++;
                $display("FAIL oob_nogap[%0d]: got d=%h v=%b b=%b s=%0d c=%0d, want d=%h v=%b b=%b s=%0d c=%0d",
                         i, dout_b, vld_b, blank_b, asel_b, drop_b, e.d, e.v, e.b, e.s, e.c);
            end
        end
        // Saturation of the 2-bit drop counter.
        rdy_b = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            push_exp(16'h0, 1'b1, 1'b0, 3'd7, CNT_EN ? 8'((i > 3) ? 3 : i) : 8'd0);
            tick();
            e = sbq.pop_front();
            checks++;
            if ({dout_b, vld_b, blank_b, asel_b, 6'd0, drop_b} !== {e.d, e.v, e.b, e.s, e.c}) begin
                errors++;
                $display("FAIL drop_saturate[%0d]: got d=%h v=%b b=%b s=%0d c=%0d, want d=%h v=%b b=%b s=%0d c=%0d",
                         i, dout_b, vld_b, blank_b, asel_b, drop_b, e.d, e.v, e.b, e.s, e.c);
            end
        end
    endtask

    initial begin
        test_reset();
        test_select();
        test_blank();
        test_backpressure();
        test_enh_drop();
        test_oob_nogap();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
